// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute for LW, SW, R-type, BEQ/BNE, ADDI/ORI and J.
// Define MEMWAIT_EN to make FETCH, MEMRD and MEMWR hold until mem_ready; otherwise mem_ready is ignored.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcen,
   output logic       irwrite,
   output logic       iord,
   output logic       memwrite,
   output logic       memtoreg,
   output logic       regdst,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] aluop,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
      MEMWB  = 4'd4,  MEMWR  = 4'd5,  RTEXE  = 4'd6,  ALUWB = 4'd7,
      BRANCH = 4'd8,  IEXE   = 4'd9,  IWB    = 4'd10, JUMP  = 4'd11
   } state_t;

   typedef struct packed {
      logic       iord;
      logic       memwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [2:0] aluop;
      logic       pcwrite;
      logic       done;
   } ctrl_t;

   state_t cur, nxt;
   ctrl_t  ctrl;
   logic   mem_done;
   logic   illegal;
   logic   fetch_done;
   logic   branch_taken;

`ifdef MEMWAIT_EN
   assign mem_done = mem_ready;
`else
   logic mem_ready_unused;
   assign mem_ready_unused = mem_ready;
   assign mem_done = 1'b1;
`endif

   // Purely state-determined outputs; op is stable from DECODE so IEXE can use it.
   function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] o);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH:  c.alusrcb = 2'b01;
         DECODE: c.alusrcb = 2'b11;
         MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         MEMRD:  c.iord = 1'b1;
         MEMWB:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; c.done = 1'b1; end
         MEMWR:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
         RTEXE:  begin c.alusrca = 1'b1; c.aluop = 3'b100; end
         ALUWB:  begin c.regdst = 1'b1; c.regwrite = 1'b1; c.done = 1'b1; end
         BRANCH: begin c.alusrca = 1'b1; c.aluop = 3'b010; c.pcsrc = 2'b01; c.done = 1'b1; end
         IEXE:   begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
            c.aluop   = (o == OP_ORI) ? 3'b001 : 3'b000;
         end
         IWB:    begin c.regwrite = 1'b1; c.done = 1'b1; end
         JUMP:   begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; c.done = 1'b1; end
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      nxt     = cur;
      illegal = 1'b0;
      case (cur)
         FETCH:  if (mem_done) nxt = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW:    nxt = MEMADR;
               OP_RTYPE:        nxt = RTEXE;
               OP_BEQ, OP_BNE:  nxt = BRANCH;
               OP_ADDI, OP_ORI: nxt = IEXE;
               OP_J:            nxt = JUMP;
               default: begin
                  nxt     = FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         MEMADR: nxt = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  if (mem_done) nxt = MEMWB;
         MEMWR:  if (mem_done) nxt = FETCH;
         RTEXE:  nxt = ALUWB;
         IEXE:   nxt = IWB;
         default: nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur  <= FETCH;
         ctrl <= decode_ctrl(FETCH, op);
      end else begin
         cur  <= nxt;
         ctrl <= decode_ctrl(nxt, op);
      end
   end

   // Terms that depend on same-cycle inputs (memory handshake, ALU zero) stay combinational.
   assign fetch_done   = (cur == FETCH) && mem_done;
   assign branch_taken = (cur == BRANCH) &&
                         (((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero));

   assign pcen       = ctrl.pcwrite | fetch_done | branch_taken;
   assign irwrite    = fetch_done;
   assign iord       = ctrl.iord;
   assign memwrite   = ctrl.memwrite;
   assign memtoreg   = ctrl.memtoreg;
   assign regdst     = ctrl.regdst;
   assign regwrite   = ctrl.regwrite;
   assign alusrca    = ctrl.alusrca;
   assign alusrcb    = ctrl.alusrcb;
   assign pcsrc      = ctrl.pcsrc;
   assign aluop      = ctrl.aluop;
   assign instr_done = ctrl.done | ((cur == MEMWR) && mem_done);
   assign illegal_op = illegal;
   assign state      = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed reset/decode checks, then random instruction stream
// scored per instruction against a table-level model of latency and control activity.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       pcen, irwrite, iord, memwrite, memtoreg, regdst, regwrite, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] aluop;
   logic       instr_done, illegal_op;
   logic [3:0] state;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pcen(pcen), .irwrite(irwrite), .iord(iord), .memwrite(memwrite),
      .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .instr_done(instr_done),
      .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   // Per-instruction summary of what the controller did
   typedef struct packed {
      logic [7:0] cycles;
      logic [3:0] n_pcen;
      logic [3:0] n_irwrite;
      logic [3:0] n_regwrite;
      logic [3:0] n_memwrite;
      logic [3:0] n_memtoreg;
      logic [3:0] n_regdst;
      logic [2:0] aluop_or;
      logic [1:0] pcsrc_or;
      logic [3:0] last_state;
      logic       illegal;
   } rec_t;
   localparam int REC_W = $bits(rec_t);

   logic [REC_W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: what one instruction should look like, from the opcode table
   function automatic rec_t model(input logic [5:0] o, input logic z, input int wf, input int wa);
      rec_t r;
      int   lat;
      r = '0;
      r.n_pcen = 4'd1;
      r.n_irwrite = 4'd1;
      case (o)
         6'b100011: begin lat = 5 + wa; r.n_regwrite = 1; r.n_memtoreg = 1; r.last_state = 4; end
         6'b101011: begin lat = 4 + wa; r.n_memwrite = 4'(1 + wa); r.last_state = 5; end
         6'b000000: begin lat = 4; r.n_regwrite = 1; r.n_regdst = 1; r.aluop_or = 3'b100; r.last_state = 7; end
         6'b000100: begin lat = 3; r.n_pcen = z ? 4'd2 : 4'd1; r.aluop_or = 3'b010; r.pcsrc_or = 2'b01; r.last_state = 8; end
         6'b000101: begin lat = 3; r.n_pcen = z ? 4'd1 : 4'd2; r.aluop_or = 3'b010; r.pcsrc_or = 2'b01; r.last_state = 8; end
         6'b001000: begin lat = 4; r.n_regwrite = 1; r.last_state = 10; end
         6'b001101: begin lat = 4; r.n_regwrite = 1; r.aluop_or = 3'b001; r.last_state = 10; end
         6'b000010: begin lat = 3; r.n_pcen = 4'd2; r.pcsrc_or = 2'b10; r.last_state = 11; end
         default:   begin lat = 2; r.illegal = 1'b1; r.last_state = 1; end
      endcase
      r.cycles = 8'(lat + wf);
      return r;
   endfunction

   function automatic int is_mem_op(input logic [5:0] o);
      return (o == 6'b100011 || o == 6'b101011) ? 1 : 0;
   endfunction

   task automatic monitor_loop();
      int n_cyc = 0, n_pc = 0, n_ir = 0, n_rw = 0, n_mw = 0, n_mtr = 0, n_rd = 0;
      logic [2:0] a_or = '0;
      logic [1:0] p_or = '0;
      rec_t act, exp;
      forever begin
         @(negedge clk);
         n_cyc++;
         n_pc  += int'(pcen);
         n_ir  += int'(irwrite);
         n_rw  += int'(regwrite);
         n_mw  += int'(memwrite);
         n_mtr += int'(memtoreg);
         n_rd  += int'(regdst);
         a_or  |= aluop;
         p_or  |= pcsrc;
         if (instr_done || illegal_op) begin
            act = '{cycles: 8'(n_cyc), n_pcen: 4'(n_pc), n_irwrite: 4'(n_ir),
                    n_regwrite: 4'(n_rw), n_memwrite: 4'(n_mw), n_memtoreg: 4'(n_mtr),
                    n_regdst: 4'(n_rd), aluop_or: a_or, pcsrc_or: p_or,
                    last_state: state, illegal: illegal_op && !instr_done};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL instr_unexpected: got %0h expected none", act);
            end else begin
               exp = rec_t'(exp_q.pop_front());
               if (act !== exp) begin
                  errors++;
                  $display("FAIL instr_record op=%0h: got %0h expected %0h", op, act, exp);
               end
            end
            n_cyc = 0; n_pc = 0; n_ir = 0; n_rw = 0; n_mw = 0; n_mtr = 0; n_rd = 0;
            a_or = '0; p_or = '0;
         end
      end
   endtask

   logic [5:0] legal_ops [10];
   initial begin
      legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                    6'b001000, 6'b001101, 6'b000010, 6'b111111, 6'b010101};
   end

   initial begin
      logic [5:0] op_v;
      logic       z_v, mr;
      int         wf, wa, lat;
      rec_t       e;

      reset = 1'b1; op = 6'b0; zero = 1'b0; mem_ready = 1'b1;
      step(); step();

      // Reset values in FETCH
      check("rst_state", 32'(state), 32'd0);
      check("rst_alusrcb", 32'(alusrcb), 32'd1);
      check("rst_pcen", 32'(pcen), 32'd1);
      check("rst_irwrite", 32'(irwrite), 32'd1);
      check("rst_done", 32'(instr_done), 32'd0);
      check("rst_illegal", 32'(illegal_op), 32'd0);
      check("rst_misc", 32'({regwrite, memwrite, iord, alusrca, memtoreg, regdst}), 32'd0);
      check("rst_alu_pc", 32'({aluop, pcsrc}), 32'd0);

      // LW into MEMRD, then reset mid-access
      reset = 1'b0; op = 6'b100011;
      step();
      check("dec_state", 32'(state), 32'd1);
      check("dec_alusrcb", 32'(alusrcb), 32'd3);
      step();
      check("madr_state", 32'(state), 32'd2);
      check("madr_alusrc", 32'({alusrca, alusrcb}), 32'b110);
      step();
      check("mrd_state", 32'(state), 32'd3);
      check("mrd_iord", 32'(iord), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_state", 32'(state), 32'd0);
      check("mid_rst_pcen", 32'(pcen), 32'd1);
      check("mid_rst_irwrite", 32'(irwrite), 32'd1);

      // Illegal opcode path
      op = 6'b111111;
      step();
      check("ill_state", 32'(state), 32'd1);
      check("ill_pulse", 32'(illegal_op), 32'd1);
      check("ill_writes", 32'({regwrite, memwrite, instr_done}), 32'd0);
      step();
      check("ill_next_state", 32'(state), 32'd0);
      check("ill_cleared", 32'(illegal_op), 32'd0);

      // Random instruction stream
      reset = 1'b1;
      step();
      reset = 1'b0;
      fork
         monitor_loop();
      join_none

      for (int n = 0; n < 300; n++) begin
         op_v = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 9)];
         z_v  = 1'($urandom_range(0, 1));
`ifdef MEMWAIT_EN
         wf = $urandom_range(0, 2);
         wa = is_mem_op(op_v) ? $urandom_range(0, 3) : 0;
`else
         wf = 0;
         wa = 0;
`endif
         e = model(op_v, z_v, wf, wa);
         exp_q.push_back(e);
         lat = int'(e.cycles);
         op = op_v;
         zero = z_v;
         for (int c = 0; c < lat; c++) begin
            mr = 1'($urandom_range(0, 1));
`ifdef MEMWAIT_EN
            if (c <= wf) mr = (c == wf);
            if (is_mem_op(op_v) != 0 && c >= wf + 3 && c <= wf + 3 + wa) mr = (c == wf + 3 + wa);
`endif
            mem_ready = mr;
            step();
         end
      end

      for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
      check("pending_records", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL provide these ports, in this order:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  6  opcode from the instruction register; stable from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pcen  out  1  PC register write enable.
- irwrite  out  1  instruction register write enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write strobe.
- memtoreg  out  1  register writeback data select: 1 = memory data.
- regdst  out  1  destination register select: 1 = rd.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- aluop  out  3  ALU operation: 000 = add, 001 = or, 010 = subtract, 100 = decode funct.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state  out  4  current state, for debug.

Function
REQ-002 The block SHALL be a Moore FSM with these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, ALUWB=7, BRANCH=8, IEXE=9, IWB=10, JUMP=11.
REQ-003 Any output not listed for a state SHALL be 0 in that state.
REQ-004 Outputs by state SHALL be:
- FETCH: alusrcb=01, irwrite=1 and internal pcwrite=1 only in a cycle where the fetch completes.
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1 in every cycle held.
- RTEXE: alusrca=1, aluop=100.
- ALUWB: regdst=1, regwrite=1.
- BRANCH: alusrca=1, aluop=010, pcsrc=01.
- IEXE: alusrca=1, alusrcb=10, aluop=000 for ADDI, 001 for ORI.
- IWB: regwrite=1.
- JUMP: pcsrc=10, internal pcwrite=1.
REQ-005 pcen SHALL equal pcwrite | (BRANCH & op==000100 & zero) | (BRANCH & op==000101 & ~zero).
REQ-006 DECODE SHALL transition on op as follows:
- 100011 (LW) or 101011 (SW) -> MEMADR.
- 000000 (R-type) -> RTEXE.
- 000100 (BEQ) or 000101 (BNE) -> BRANCH.
- 001000 (ADDI) or 001101 (ORI) -> IEXE.
- 000010 (J) -> JUMP.
- any other opcode -> FETCH, with illegal_op=1 for that cycle.
REQ-007 The remaining transitions SHALL be:
- MEMADR -> MEMRD for LW, MEMWR for SW.
- MEMRD -> MEMWB.
- RTEXE -> ALUWB; IEXE -> IWB.
- MEMWB, MEMWR, ALUWB, IWB, BRANCH, JUMP -> FETCH.
REQ-008 instr_done SHALL be 1 in MEMWB, ALUWB, IWB, BRANCH and JUMP; in MEMWR only in the completing cycle; and never on the illegal-opcode path.
REQ-009 Instruction latency with zero wait states SHALL be: LW 5; SW, R-type, ADDI, ORI 4; BEQ, BNE, J 3 cycles.

Reset
REQ-010 With reset high at a clk edge, state SHALL become FETCH from any state, including mid-access or wait-held states.
REQ-011 While in FETCH after reset, outputs SHALL be the FETCH values of REQ-004; instr_done=0 and illegal_op=0.

Configuration
REQ-012 With macro MEMWAIT_EN defined:
- FETCH, MEMRD and MEMWR SHALL hold until mem_ready=1.
- The access completes in the cycle mem_ready=1; mem_ready is ignored in every other state.
REQ-013 With MEMWAIT_EN undefined:
- mem_ready SHALL be ignored.
- FETCH, MEMRD and MEMWR each complete in one cycle.

Verification
REQ-014 Reset in MEMRD: reset=1 for one edge -> state=0; pcen=1 and irwrite=1 the next cycle (mem_ready=1).
REQ-015 LW (op=100011), mem_ready=1 throughout -> states 0,1,2,3,4; instr_done only in state 4; regwrite=1 and memtoreg=1 in state 4.
REQ-016 BNE (op=000101) -> state 8 with zero=0 gives pcen=1, pcsrc=01; with zero=1 gives pcen=0.
REQ-017 MEMWAIT_EN, SW (op=101011), mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 cycles, instr_done on the 4th, then FETCH.
REQ-018 op=111111 in DECODE -> illegal_op=1 for one cycle, next state 0, regwrite and memwrite never 1.
REQ-019 ORI (op=001101) -> IEXE with aluop=001 and alusrcb=10; IWB with regwrite=1 and regdst=0.
